// File: rtl/regfile_wbuf.sv
// Write-back buffer in front of the register file write port: queues result
// writes, drains one per enabled cycle, and bypasses queued data to readers.
module regfile_wbuf #(
   parameter int AW    = 6,
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int RP    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   output logic                     in_ready,
   input  logic                     drain_en,
   output logic                     wr_valid,
   output logic [AW-1:0]            wr_addr,
   output logic [DW-1:0]            wr_data,
   input  logic [RP*AW-1:0]         rd_addr,
   output logic [RP-1:0]            byp_hit,
   output logic [RP*DW-1:0]         byp_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [AW-1:0]    addr_mem [DEPTH];
   logic [DW-1:0]    data_mem [DEPTH];
   logic [DEPTH-1:0] vld_reg;
   logic [DEPTH-1:0] vld_next;
   logic [PW-1:0]    head_reg;
   logic [PW-1:0]    tail_reg;
   logic [CW-1:0]    count_reg;
   logic             push;
   logic             pop;

   // Flow control depends only on registered occupancy.
   assign in_ready = (count_reg != FULL_COUNT);
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign push     = in_valid & in_ready;
   assign pop      = drain_en & ~empty;

   assign wr_valid = pop;
   assign wr_addr  = addr_mem[head_reg];
   assign wr_data  = data_mem[head_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + PW'(1);
         end
         if (pop) begin
            head_reg <= head_reg + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Push and pop never target the same slot: that needs full (push blocked)
   // or empty (pop blocked).
   always_comb begin
      vld_next = vld_reg;
      if (push) begin
         vld_next[tail_reg] = 1'b1;
      end
      if (pop) begin
         vld_next[head_reg] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
      end else begin
         vld_reg <= vld_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_reg] <= in_addr;
         data_mem[tail_reg] <= in_data;
      end
   end

   // Walk entries oldest-to-youngest starting at head so the last match wins,
   // which keeps age order correct across pointer wrap.
   genvar gi;
   generate
      for (gi = 0; gi < RP; gi++) begin : g_byp
         logic [AW-1:0] look_addr;
         logic          hit_next;
         logic [DW-1:0] data_next;
         logic [PW-1:0] idx;

         assign look_addr = rd_addr[gi*AW +: AW];

         always_comb begin
            hit_next  = 1'b0;
            data_next = '0;
            idx       = '0;
            for (int k = 0; k < DEPTH; k++) begin
               idx = head_reg + PW'(k);
               if (vld_reg[idx] && (addr_mem[idx] == look_addr)) begin
                  hit_next  = 1'b1;
                  data_next = data_mem[idx];
               end
            end
         end

         assign byp_hit[gi]            = hit_next;
         assign byp_data[gi*DW +: DW]  = data_next;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_wbuf.sv
// Randomised and directed bench for regfile_wbuf against a queue-based model.
module tb_regfile_wbuf;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int RP    = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic [AW-1:0]        in_addr = '0;
   logic [DW-1:0]        in_data = '0;
   logic                 in_ready;
   logic                 drain_en = 1'b0;
   logic                 wr_valid;
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic [RP*AW-1:0]     rd_addr = '0;
   logic [RP-1:0]        byp_hit;
   logic [RP*DW-1:0]     byp_data;
   logic [2:0]           count;
   logic                 empty;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   int   push_total = 0;

   regfile_wbuf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RP(RP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
      .drain_en(drain_en),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .byp_hit(byp_hit), .byp_data(byp_data),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of pending writes, updated by the handshake rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         push_total = 0;
      end else begin
         bit do_push;
         bit do_pop;
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = drain_en && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back('{a: in_addr, d: in_data});
            push_total++;
         end
      end
   end

   always @(negedge clk) begin
      bit exp_wv;
      exp_wv = drain_en && (q.size() > 0) && !rst;
      chk("cmp_in_ready", in_ready, q.size() != DEPTH);
      chk("cmp_count", count, q.size());
      chk("cmp_empty", empty, q.size() == 0);
      chk("cmp_wr_valid", wr_valid, exp_wv);
      if (exp_wv) begin
         chk("cmp_wr_addr", wr_addr, q[0].a);
         chk("cmp_wr_data", wr_data, q[0].d);
      end
      for (int p = 0; p < RP; p++) begin
         logic [AW-1:0] ra;
         logic          h;
         logic [DW-1:0] d;
         ra = rd_addr[p*AW +: AW];
         h  = 1'b0;
         d  = '0;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ra) begin
               h = 1'b1;
               d = q[i].d;
               break;
            end
         end
         chk($sformatf("cmp_byp_hit%0d", p), byp_hit[p], h);
         chk($sformatf("cmp_byp_data%0d", p), byp_data[p*DW +: DW], d);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_all();
      in_valid = 1'b0;
      drain_en = 1'b1;
      for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) cyc();
      chk("drain_empty", empty, 1'b1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drain_en = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_empty", empty, 1'b1);
      chk("rst_count", count, 3'd0);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_byp_hit", byp_hit, 2'b00);

      // Single write, one-cycle latency, no write-through
      in_valid = 1'b1; in_addr = 6'd5; in_data = 32'hAAAA0001;
      #1 chk("t1_no_write_through", wr_valid, 1'b0);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("t1_wr_valid", wr_valid, 1'b1);
      chk("t1_wr_addr", wr_addr, 6'd5);
      chk("t1_wr_data", wr_data, 32'hAAAA0001);
      cyc();
      #1;
      chk("t1_empty", empty, 1'b1);
      chk("t1_count", count, 3'd0);

      // Fill, hold off a fifth, drain in order
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_addr = AW'(i); in_data = 32'h100 + i;
         cyc();
      end
      in_addr = 6'd5; in_data = 32'h105;
      #1;
      chk("t2_count_full", count, 3'd4);
      chk("t2_in_ready", in_ready, 1'b0);
      cyc();
      in_valid = 1'b0; drain_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("t2_wr_addr", wr_addr, AW'(i));
         if (i == 2) chk("t2_ready_after_pop", in_ready, 1'b1);
         cyc();
      end
      #1 chk("t2_empty", empty, 1'b1);

      // Youngest duplicate wins; miss gives zero
      drain_en = 1'b0;
      in_valid = 1'b1; in_addr = 6'd7; in_data = 32'h11; cyc();
      in_addr = 6'd7; in_data = 32'h22; cyc();
      in_valid = 1'b0;
      rd_addr = {6'd8, 6'd7};
      #1;
      chk("t3_byp_hit", byp_hit, 2'b01);
      chk("t3_byp_data0", byp_data[31:0], 32'h22);
      chk("t3_byp_data1", byp_data[63:32], 32'h0);

      // Full with simultaneous pop: push blocked, then accepted next cycle
      in_valid = 1'b1; in_addr = 6'd10; in_data = 32'hA0; cyc();
      in_addr = 6'd11; in_data = 32'hB0; cyc();
      in_addr = 6'd12; in_data = 32'h33; drain_en = 1'b1;
      #1;
      chk("t4_count4", count, 3'd4);
      chk("t4_wr_addr", wr_addr, 6'd7);
      chk("t4_in_ready", in_ready, 1'b0);
      cyc();
      #1;
      chk("t4_count3", count, 3'd3);
      chk("t4_wr_data", wr_data, 32'h22);
      cyc();
      #1;
      chk("t4_count_still3", count, 3'd3);
      chk("t4_wr_addr2", wr_addr, 6'd10);
      drain_all();

      // Wrap the pointers, then place addr 9 in slots 3 (older) and 0 (younger)
      in_valid = 1'b1; drain_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_addr = AW'(20 + i); in_data = $urandom; cyc();
      end
      drain_all();
      for (int i = 0; i < DEPTH && (push_total % DEPTH) != 3; i++) begin
         in_valid = 1'b1; in_addr = 6'd40; in_data = $urandom; cyc();
         in_valid = 1'b0; cyc();
      end
      drain_en = 1'b0;
      in_valid = 1'b1; in_addr = 6'd9; in_data = 32'h900; cyc();
      in_addr = 6'd9; in_data = 32'h901; cyc();
      in_valid = 1'b0;
      rd_addr = {6'd9, 6'd9};
      #1;
      chk("t5_byp_hit", byp_hit, 2'b11);
      chk("t5_byp_data0", byp_data[31:0], 32'h901);
      chk("t5_byp_data1", byp_data[63:32], 32'h901);
      drain_all();

      // Async reset with three queued writes
      drain_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_addr = AW'(30 + i); in_data = 32'hC0 + i; cyc();
      end
      in_valid = 1'b0; drain_en = 1'b1; rd_addr = {6'd31, 6'd30};
      #1 chk("t6_pre_count", count, 3'd3);
      rst = 1'b1;
      #1;
      chk("t6_wr_valid", wr_valid, 1'b0);
      chk("t6_byp_hit", byp_hit, 2'b00);
      chk("t6_count", count, 3'd0);
      repeat (2) cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t6_no_replay", wr_valid, 1'b0);
         cyc();
      end

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_addr  = AW'($urandom_range(0, 7));
         in_data  = $urandom;
         drain_en = ($urandom_range(0, 2) != 0) ? (n % 200 < 120) : 1'b0;
         rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
